// File: rtl/digit_entry_ctrl.sv
// Keypad digit-entry controller for a microwave-style timer.
// Debounces key presses and release, then shifts accepted BCD digits into
// a four-digit MM:SS register. One acceptance per physical press; rejected
// presses (locked, non-decimal key, register full, or wiped by clear) give
// a one-cycle reject pulse instead.
module digit_entry_ctrl #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       key_valid,
    input  logic       clear,
    input  logic       lock,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [2:0] digit_count,
    output logic       full,
    output logic       key_accept,
    output logic       reject
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [4:0] DEB_L = 5'(DEBOUNCE);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] sec_ones_q;
    logic [3:0] sec_tens_q;
    logic [3:0] min_ones_q;
    logic [3:0] min_tens_q;
    logic [2:0] count_q;
    logic       accept_q;
    logic       reject_q;

    logic [4:0] cnt_inc_s;
    logic       accept_edge_s;
    logic       discard_s;
    logic       full_s;

    assign full_s      = (count_q == 3'd4);
    assign full        = full_s;
    assign sec_ones    = sec_ones_q;
    assign sec_tens    = sec_tens_q;
    assign min_ones    = min_ones_q;
    assign min_tens    = min_tens_q;
    assign digit_count = count_q;
    assign key_accept  = accept_q;
    assign reject      = reject_q;

    // Detect the edge on which a press completes qualification and whether it must be discarded.
    always_comb begin
        cnt_inc_s     = {1'b0, cnt_q} + 5'd1;
        accept_edge_s = 1'b0;
        case (state_q)
            IDLE:       accept_edge_s = key_valid && (DEB_L == 5'd1);
            PRESS_WAIT: accept_edge_s = key_valid && (cnt_inc_s == DEB_L);
            default:    accept_edge_s = 1'b0;
        endcase
        discard_s = lock || (digit > 4'd9) || full_s;
    end

    // Debounce FSM plus the digit shift register and its one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            count_q    <= 3'd0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        cnt_q   <= 4'd1;
                        state_q <= accept_edge_s ? HELD : PRESS_WAIT;
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_valid) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (accept_edge_s) begin
                        state_q <= HELD;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_inc_s[3:0];
                    end
                end
                HELD: begin
                    // A held key never re-qualifies; only a release moves on.
                    if (!key_valid) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= 4'd1;
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_valid) begin
                        state_q <= HELD;
                        cnt_q   <= 4'd0;
                    end else if (cnt_inc_s >= DEB_L) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_inc_s[3:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase

            // Clear wins over a coincident acceptance, which is then reported as rejected.
            if (clear) begin
                sec_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                min_ones_q <= 4'd0;
                min_tens_q <= 4'd0;
                count_q    <= 3'd0;
                reject_q   <= accept_edge_s;
            end else if (accept_edge_s) begin
                if (discard_s) begin
                    reject_q <= 1'b1;
                end else begin
                    min_tens_q <= min_ones_q;
                    min_ones_q <= sec_tens_q;
                    sec_tens_q <= sec_ones_q;
                    sec_ones_q <= digit;
                    count_q    <= count_q + 3'd1;
                    accept_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Scoreboard bench for digit_entry_ctrl (DEBOUNCE = 4). Each qualified
// press pushes its expected pulse kind, cycle and resulting register state;
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_digit_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit;
    logic       key_valid;
    logic       clear;
    logic       lock;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [2:0] digit_count;
    logic       full;
    logic       key_accept;
    logic       reject;

    typedef struct {
        int          kind;   // 1 = key_accept, 2 = reject
        int          cyc;
        logic [15:0] dig;    // {min_tens, min_ones, sec_tens, sec_ones}
        int          cnt;
    } ev_t;

    ev_t         sbq[$];
    ev_t         mon_ev;
    int          cyc      = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          acc_seen = 0;
    logic [15:0] m_dig    = 16'h0000;
    int          m_cnt    = 0;

    digit_entry_ctrl #(.DEBOUNCE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .digit      (digit),
        .key_valid  (key_valid),
        .clear      (clear),
        .lock       (lock),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .digit_count(digit_count),
        .full       (full),
        .key_accept (key_accept),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, m_dig);
        check_eq({tag, "_count"}, digit_count, m_cnt);
        check_eq({tag, "_full"}, full, (m_cnt == 4));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one press of digit d: hi cycles high, lo cycles low; optional lock / clear on 4th edge.
    task automatic press(input logic [3:0] d, input int hi, input int lo,
                         input logic lk, input logic clr_acc);
        ev_t e;
        digit     = d;
        lock      = lk;
        key_valid = 1'b1;
        if (hi >= 4) begin
            e.cyc = cyc + 4;
            if (clr_acc) begin
                m_dig  = 16'h0000;
                m_cnt  = 0;
                e.kind = 2;
            end else if (lk || (d > 4'd9) || (m_cnt == 4)) begin
                e.kind = 2;
            end else begin
                m_dig  = {m_dig[11:0], d};
                m_cnt  = m_cnt + 1;
                e.kind = 1;
            end
            e.dig = m_dig;
            e.cnt = m_cnt;
            sbq.push_back(e);
        end
        for (int i = 0; i < hi; i++) begin
            clear = clr_acc && (i == 3);
            tick(1);
        end
        clear     = 1'b0;
        key_valid = 1'b0;
        lock      = 1'b0;
        tick(lo);
    endtask

    // Pop the scoreboard on every observed pulse and compare kind, timing and register state.
    always @(negedge clk) begin
        if (!rst && (key_accept || reject)) begin
            if (sbq.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, reject, key_accept}, 32'd0);
            end else begin
                mon_ev = sbq.pop_front();
                check_eq("pulse_kind", {30'd0, reject, key_accept}, mon_ev.kind);
                check_eq("pulse_cyc", cyc, mon_ev.cyc);
                check_eq("pulse_digits", {min_tens, min_ones, sec_tens, sec_ones}, mon_ev.dig);
                check_eq("pulse_count", digit_count, mon_ev.cnt);
            end
            if (key_accept) acc_seen++;
        end
    end

    initial begin
        rst       = 1'b1;
        digit     = 4'd0;
        key_valid = 1'b0;
        clear     = 1'b0;
        lock      = 1'b0;
        tick(2);
        check_state("reset");
        check_eq("reset_pulses", {reject, key_accept}, 2'b00);
        rst = 1'b0;
        tick(1);

        // Basic entry 1, 3, 0
        press(4'd1, 6, 6, 1'b0, 1'b0);
        press(4'd3, 6, 6, 1'b0, 1'b0);
        press(4'd0, 6, 6, 1'b0, 1'b0);
        check_state("entry130");
        check_eq("entry130_accepts", acc_seen, 3);

        // Short glitch must be ignored
        press(4'd7, 3, 6, 1'b0, 1'b0);
        check_state("glitch");
        check_eq("glitch_accepts", acc_seen, 3);

        // Long hold yields exactly one acceptance, fills the register
        press(4'd2, 50, 6, 1'b0, 1'b0);
        check_eq("hold50_accepts", acc_seen, 4);
        check_state("hold50");

        // Standalone clear
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_dig = 16'h0000;
        m_cnt = 0;
        tick(1);
        check_state("clear");

        // Overflow
        press(4'd1, 6, 6, 1'b0, 1'b0);
        press(4'd2, 6, 6, 1'b0, 1'b0);
        press(4'd3, 6, 6, 1'b0, 1'b0);
        press(4'd4, 6, 6, 1'b0, 1'b0);
        check_state("full1234");
        press(4'd5, 6, 6, 1'b0, 1'b0);
        check_state("overflow");

        // Lock and non-decimal key
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_dig = 16'h0000;
        m_cnt = 0;
        press(4'd6, 6, 6, 1'b1, 1'b0);
        check_state("lock");
        press(4'hA, 6, 6, 1'b0, 1'b0);
        check_state("digitA");

        // Clear coincident with acceptance
        press(4'd3, 6, 6, 1'b0, 1'b0);
        press(4'd5, 6, 6, 1'b0, 1'b1);
        check_state("clear_acc");

        // Reset mid-press with key held through reset
        press(4'd7, 6, 6, 1'b0, 1'b0);
        digit     = 4'd9;
        key_valid = 1'b1;
        tick(2);
        rst = 1'b1;
        #1;
        m_dig = 16'h0000;
        m_cnt = 0;
        check_state("rst_async");
        check_eq("rst_async_pulses", {reject, key_accept}, 2'b00);
        tick(2);
        begin
            ev_t e;
            m_dig  = 16'h0009;
            m_cnt  = 1;
            e.kind = 1;
            e.cyc  = cyc + 4;
            e.dig  = m_dig;
            e.cnt  = m_cnt;
            sbq.push_back(e);
        end
        rst = 1'b0;
        tick(6);
        key_valid = 1'b0;
        tick(8);
        check_state("post_rst");

        check_eq("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
